// File: rtl/sram_read_scheduler.sv
// Round-robin, single-outstanding read scheduler in front of the SRAM bus read port.
// Optional watchdog on the WAIT state is enabled with `define SRAM_SCHED_TIMEOUT_EN.
module sram_read_scheduler #(
  parameter int unsigned ADDRESS_BUS_WIDTH = 16,
  parameter int unsigned DATA_BUS_WIDTH    = 16,
  parameter int unsigned REQUESTER_COUNT   = 4,
  parameter int unsigned TIMEOUT_CYCLES    = 15
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [REQUESTER_COUNT-1:0]                     req_valid,
  input  logic [REQUESTER_COUNT*ADDRESS_BUS_WIDTH-1:0]   req_address,
  output logic [REQUESTER_COUNT-1:0]                     req_ready,
  output logic [REQUESTER_COUNT-1:0]                     rsp_valid,
  output logic [DATA_BUS_WIDTH-1:0]                      rsp_data,
  output logic                                           rsp_error,
  output logic                                           bus_read_request,
  output logic [ADDRESS_BUS_WIDTH-1:0]                   bus_read_address,
  input  logic                                           bus_read_finished,
  input  logic [DATA_BUS_WIDTH-1:0]                      bus_read_data,
  output logic                                           busy
);

  localparam int unsigned AW = ADDRESS_BUS_WIDTH;
  localparam int unsigned DW = DATA_BUS_WIDTH;
  localparam int unsigned N  = REQUESTER_COUNT;
  localparam int unsigned PW = $clog2(REQUESTER_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [PW-1:0]   grant, grant_next;
  logic [PW-1:0]   rr_ptr, rr_ptr_next;
  logic [AW-1:0]   address_next;
  logic [N-1:0]    req_ready_next;
  logic [N-1:0]    rsp_valid_next;
  logic [DW-1:0]   rsp_data_next;
  logic            bus_read_request_next;
  logic            busy_next;

  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   cand;
  logic [AW-1:0]   win_address;
  int unsigned     cand_sum;

`ifdef SRAM_SCHED_TIMEOUT_EN
  localparam logic [3:0] TIMEOUT_LIMIT = 4'(TIMEOUT_CYCLES);
  logic [3:0]      wait_count, wait_count_next;
  logic [3:0]      wait_count_inc;
  logic            rsp_error_next;

  assign wait_count_inc = wait_count + 4'd1;
`else
  logic            unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign rsp_error      = 1'b0;
`endif

  // First requesting client at or after rr_ptr, wrapping modulo N
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    cand_sum  = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand_sum = 32'(rr_ptr) + i;
      if (cand_sum >= N) begin
        cand_sum = cand_sum - N;
      end
      cand = PW'(cand_sum);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_address = req_address[32'(win_idx)*AW +: AW];
  end

  // Next-state and next-output logic
  always_comb begin
    state_next            = state;
    grant_next            = grant;
    rr_ptr_next           = rr_ptr;
    address_next          = bus_read_address;
    req_ready_next        = '0;
    rsp_valid_next        = '0;
    rsp_data_next         = rsp_data;
    bus_read_request_next = 1'b0;
`ifdef SRAM_SCHED_TIMEOUT_EN
    wait_count_next       = wait_count;
    rsp_error_next        = 1'b0;
`endif

    unique case (state)
      ST_IDLE: begin
        if (win_found) begin
          state_next            = ST_ISSUE;
          grant_next            = win_idx;
          address_next          = win_address;
          req_ready_next        = N'(1) << win_idx;
          bus_read_request_next = 1'b1;
        end
      end
      ST_ISSUE: begin
        rr_ptr_next = (grant == PW'(N - 1)) ? '0 : PW'(grant + 1'b1);
        if (bus_read_finished) begin
          state_next     = ST_RESPOND;
          rsp_data_next  = bus_read_data;
          rsp_valid_next = N'(1) << grant;
        end else begin
          state_next = ST_WAIT;
`ifdef SRAM_SCHED_TIMEOUT_EN
          wait_count_next = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (bus_read_finished) begin
          state_next     = ST_RESPOND;
          rsp_data_next  = bus_read_data;
          rsp_valid_next = N'(1) << grant;
        end
`ifdef SRAM_SCHED_TIMEOUT_EN
        // A finished strobe on the limit cycle takes precedence over the timeout
        else if (wait_count_inc == TIMEOUT_LIMIT) begin
          state_next     = ST_RESPOND;
          rsp_data_next  = '0;
          rsp_valid_next = N'(1) << grant;
          rsp_error_next = 1'b1;
        end else begin
          wait_count_next = wait_count_inc;
        end
`endif
      end
      ST_RESPOND: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= ST_IDLE;
      grant            <= '0;
      rr_ptr           <= '0;
      bus_read_address <= '0;
      req_ready        <= '0;
      rsp_valid        <= '0;
      rsp_data         <= '0;
      bus_read_request <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state            <= state_next;
      grant            <= grant_next;
      rr_ptr           <= rr_ptr_next;
      bus_read_address <= address_next;
      req_ready        <= req_ready_next;
      rsp_valid        <= rsp_valid_next;
      rsp_data         <= rsp_data_next;
      bus_read_request <= bus_read_request_next;
      busy             <= busy_next;
    end
  end

`ifdef SRAM_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_count <= '0;
      rsp_error  <= 1'b0;
    end else begin
      wait_count <= wait_count_next;
      rsp_error  <= rsp_error_next;
    end
  end
`endif

endmodule

// File: tb/tb_sram_read_scheduler.sv
// Directed bench for sram_read_scheduler: scoreboard of expected grants/responses,
// checked with immediate assertions. Honours SRAM_SCHED_TIMEOUT_EN when defined.
module tb_sram_read_scheduler;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned N  = 4;

  typedef struct {
    int          g;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_address;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_error;
  logic            bus_read_request;
  logic [AW-1:0]   bus_read_address;
  logic            bus_read_finished;
  logic [DW-1:0]   bus_read_data;
  logic            busy;

  int checks   = 0;
  int failures = 0;
  exp_t q[$];
  logic [15:0] caddr [N];

  sram_read_scheduler #(
    .ADDRESS_BUS_WIDTH(AW),
    .DATA_BUS_WIDTH   (DW),
    .REQUESTER_COUNT  (N),
    .TIMEOUT_CYCLES   (15)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_address      (req_address),
    .req_ready        (req_ready),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .rsp_error        (rsp_error),
    .bus_read_request (bus_read_request),
    .bus_read_address (bus_read_address),
    .bus_read_finished(bus_read_finished),
    .bus_read_data    (bus_read_data),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'h0);
    chk({tag, "_rsp_error"}, 32'(rsp_error), 32'h0);
    chk({tag, "_bus_req"}, 32'(bus_read_request), 32'h0);
    chk({tag, "_bus_addr"}, 32'(bus_read_address), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_rr_ptr"}, 32'(dut.rr_ptr), 32'h0);
  endtask

  task automatic push(input int g, input logic [15:0] data);
    exp_t e;
    e.g    = g;
    e.addr = caddr[g];
    e.data = data;
    q.push_back(e);
  endtask

  // One edge from IDLE: the head of the scoreboard must be granted and issued
  task automatic grant_step();
    exp_t e;
    tick();
    if (q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL grant_scoreboard_empty observed=0 expected=1");
    end else begin
      e = q[0];
      chk("grant_req_ready", 32'(req_ready), 32'(4'b0001 << e.g));
      chk("grant_bus_req", 32'(bus_read_request), 32'h1);
      chk("grant_bus_addr", 32'(bus_read_address), 32'(e.addr));
      chk("grant_busy", 32'(busy), 32'h1);
      chk("grant_no_rsp", 32'(rsp_valid), 32'h0);
    end
  endtask

  task automatic run_txn(input logic [N-1:0] next_valid, input int lat);
    exp_t e;
    grant_step();
    e = q[0];
    req_valid = next_valid;
    for (int i = 0; i < lat; i++) begin
      tick();
      chk("wait_no_rsp", 32'(rsp_valid), 32'h0);
      chk("wait_no_bus_req", 32'(bus_read_request), 32'h0);
    end
    bus_read_finished = 1'b1;
    bus_read_data     = e.data;
    tick();
    bus_read_finished = 1'b0;
    bus_read_data     = 16'hDEAD;
    e = q.pop_front();
    chk("rsp_valid", 32'(rsp_valid), 32'(4'b0001 << e.g));
    chk("rsp_data", 32'(rsp_data), 32'(e.data));
    chk("rsp_error", 32'(rsp_error), 32'h0);
    chk("rsp_busy", 32'(busy), 32'h1);
    tick();
    chk("idle_rsp_clear", 32'(rsp_valid), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_rsp_data_held", 32'(rsp_data), 32'(e.data));
  endtask

  initial begin
    caddr[0] = 16'h0A00;
    caddr[1] = 16'h1B11;
    caddr[2] = 16'h4123;
    caddr[3] = 16'h7E33;
    req_address       = {caddr[3], caddr[2], caddr[1], caddr[0]};
    rst               = 1'b0;
    req_valid         = '0;
    bus_read_finished = 1'b0;
    bus_read_data     = '0;

    // Reset state
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b1;
    tick();

    // Fairness: all four held, eight transactions, mixed bus latencies
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      push(i % 4, 16'hC000 + 16'(i));
    end
    for (int i = 0; i < 8; i++) begin
      run_txn((i == 7) ? 4'b0000 : 4'b1111, i % 3);
    end
    chk("fair_rr_ptr", 32'(dut.rr_ptr), 32'h0);

    // Single client 2, data two cycles after the request
    req_valid = 4'b0100;
    push(2, 16'hBEEF);
    run_txn(4'b0000, 2);
    chk("single_rr_ptr", 32'(dut.rr_ptr), 32'h3);

    // Wrap-around from rr_ptr=3 with clients 0 and 3
    req_valid = 4'b1001;
    push(3, 16'h3333);
    push(0, 16'h0000);
    push(3, 16'h3CC3);
    run_txn(4'b1001, 1);
    run_txn(4'b1000, 0);
    run_txn(4'b0000, 3);
    chk("wrap_rr_ptr", 32'(dut.rr_ptr), 32'h0);

    // Withdrawal and stray finished strobe in IDLE
    req_valid = 4'b0100;
    push(2, 16'h2468);
    run_txn(4'b0010, 1);
    req_valid         = 4'b0000;
    bus_read_finished = 1'b1;
    bus_read_data     = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus_read_finished = 1'b0;
      chk("withdraw_no_ready", 32'(req_ready), 32'h0);
      chk("withdraw_no_rsp", 32'(rsp_valid), 32'h0);
      chk("withdraw_idle", 32'(busy), 32'h0);
      chk("withdraw_no_bus_req", 32'(bus_read_request), 32'h0);
      chk("withdraw_data_held", 32'(rsp_data), 32'h2468);
    end

    // Reset asserted mid-WAIT
    req_valid = 4'b1001;
    push(3, 16'hFFFF);
    grant_step();
    tick();
    tick();
    req_valid = 4'b0000;
    rst = 1'b0;
    #1;
    chk_all_zero("midreset");
    void'(q.pop_front());
    tick();
    rst = 1'b1;
    bus_read_finished = 1'b1;
    bus_read_data     = 16'h7777;
    tick();
    bus_read_finished = 1'b0;
    chk("late_fin_no_rsp", 32'(rsp_valid), 32'h0);
    chk("late_fin_idle", 32'(busy), 32'h0);
    tick();
    chk("late_fin_no_rsp2", 32'(rsp_valid), 32'h0);
    req_valid = 4'b1001;
    push(0, 16'hA0A0);
    push(3, 16'hA3A3);
    run_txn(4'b1000, 1);
    run_txn(4'b0000, 2);

    // Bus never finishes
    req_valid = 4'b0010;
    push(1, 16'h0000);
    grant_step();
    req_valid = 4'b0000;
`ifdef SRAM_SCHED_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_wait_no_rsp", 32'(rsp_valid), 32'h0);
    end
    tick();
    void'(q.pop_front());
    chk("to_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("to_rsp_error", 32'(rsp_error), 32'h1);
    chk("to_rsp_data", 32'(rsp_data), 32'h0);
    tick();
    chk("to_idle", 32'(busy), 32'h0);
    chk("to_error_clear", 32'(rsp_error), 32'h0);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("nto_busy", 32'(busy), 32'h1);
      chk("nto_no_rsp", 32'(rsp_valid), 32'h0);
    end
    void'(q.pop_front());
    rst = 1'b0;
    #1;
    chk("nto_reset_busy", 32'(busy), 32'h0);
    tick();
    rst = 1'b1;
`endif

    chk("scoreboard_empty", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
